// File: rtl/de1_cl_inputs_responder.sv
// Board-less stand-in for the DE1-CL switch shift chain and rotary encoders; `DE1_CL_INPUTS_RESPONDER_ROTARY_EN builds the encoders.
// sr_data trails a load or shift by two cycles; each encoder step takes 3*STEP_DWELL cycles with ready low and no queueing.
module de1_cl_inputs_responder #(
  parameter int SR_WIDTH   = 16,
  parameter int STEP_DWELL = 8
) (
  input  logic                clk,
  input  logic                clk__enable,
  input  logic                reset,
  input  logic                inputs_control__sr_clock,
  input  logic                inputs_control__sr_shift,
  input  logic [SR_WIDTH-1:0] switches,
  output logic                inputs_status__sr_data,
  output logic [7:0]          sr_bit_count,
  input  logic                left_step_valid,
  input  logic                left_step_dir,
  output logic                left_step_ready,
  input  logic                right_step_valid,
  input  logic                right_step_dir,
  output logic                right_step_ready,
  output logic                inputs_status__left_rotary__direction_pin,
  output logic                inputs_status__left_rotary__transition_pin,
  output logic                inputs_status__right_rotary__direction_pin,
  output logic                inputs_status__right_rotary__transition_pin
);

  localparam logic [7:0] SR_W8 = 8'(SR_WIDTH);

  logic [SR_WIDTH-1:0] shreg_q, shreg_d;
  logic [7:0]          bit_cnt_q, bit_cnt_d;
  logic                sr_clock_prev_q;
  logic                sr_data_q;
  logic                rise;

  assign rise = inputs_control__sr_clock & ~sr_clock_prev_q;

  // Load has priority over a coincident shift-clock rise; shifted-in ones model the pull-up.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (!inputs_control__sr_shift) begin
      shreg_d   = switches;
      bit_cnt_d = 8'd0;
    end else if (rise) begin
      shreg_d = {shreg_q[SR_WIDTH-2:0], 1'b1};
      if (bit_cnt_q < SR_W8) begin
        bit_cnt_d = bit_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q         <= '1;
      bit_cnt_q       <= 8'd0;
      sr_clock_prev_q <= 1'b0;
      sr_data_q       <= 1'b1;
    end else if (clk__enable) begin
      shreg_q         <= shreg_d;
      bit_cnt_q       <= bit_cnt_d;
      sr_clock_prev_q <= inputs_control__sr_clock;
      sr_data_q       <= shreg_q[SR_WIDTH-1];
    end
  end

  assign inputs_status__sr_data = sr_data_q;
  assign sr_bit_count           = bit_cnt_q;

`ifdef DE1_CL_INPUTS_RESPONDER_ROTARY_EN
  typedef enum logic [1:0] {
    ROT_IDLE  = 2'd0,
    ROT_SETUP = 2'd1,
    ROT_PULSE = 2'd2,
    ROT_HOLD  = 2'd3
  } rot_state_e;

  localparam logic [7:0] DWELL_M1 = 8'(STEP_DWELL - 1);

  logic [1:0] step_vld, step_dir, step_rdy, dir_pin, trans_pin;

  assign step_vld = {right_step_valid, left_step_valid};
  assign step_dir = {right_step_dir, left_step_dir};

  // Index 0 is the left encoder, index 1 the right.
  for (genvar g = 0; g < 2; g++) begin : g_rot
    rot_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      case (state_q)
        ROT_IDLE: begin
          if (step_vld[g]) begin
            dir_d   = step_dir[g];
            cnt_d   = DWELL_M1;
            state_d = ROT_SETUP;
          end
        end
        ROT_SETUP, ROT_PULSE, ROT_HOLD: begin
          if (cnt_q == 8'd0) begin
            cnt_d = DWELL_M1;
            case (state_q)
              ROT_SETUP: state_d = ROT_PULSE;
              ROT_PULSE: state_d = ROT_HOLD;
              default:   state_d = ROT_IDLE;
            endcase
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = ROT_IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ROT_IDLE;
        cnt_q   <= 8'd0;
        dir_q   <= 1'b0;
      end else if (clk__enable) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        dir_q   <= dir_d;
      end
    end

    assign step_rdy[g]  = (state_q == ROT_IDLE);
    assign trans_pin[g] = (state_q == ROT_PULSE);
    assign dir_pin[g]   = dir_q;
  end

  assign left_step_ready                             = step_rdy[0];
  assign right_step_ready                            = step_rdy[1];
  assign inputs_status__left_rotary__direction_pin   = dir_pin[0];
  assign inputs_status__left_rotary__transition_pin  = trans_pin[0];
  assign inputs_status__right_rotary__direction_pin  = dir_pin[1];
  assign inputs_status__right_rotary__transition_pin = trans_pin[1];
`else
  logic unused_step;
  assign unused_step = &{1'b0, left_step_valid, left_step_dir, right_step_valid, right_step_dir};

  assign left_step_ready                             = 1'b0;
  assign right_step_ready                            = 1'b0;
  assign inputs_status__left_rotary__direction_pin   = 1'b0;
  assign inputs_status__left_rotary__transition_pin  = 1'b0;
  assign inputs_status__right_rotary__direction_pin  = 1'b0;
  assign inputs_status__right_rotary__transition_pin = 1'b0;
`endif

endmodule
